// File: rtl/dmem_pkg.sv
// Shared encodings and lane-mask helper for the byte-lane data memory.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [3:0] MMIO_TAG = 4'hF;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } dmem_state_e;

   // Byte lanes touched by an access; illegal sizes touch nothing.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << addr_lo;
         SZ_HALF: m = 4'b0011 << addr_lo;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// One 8-bit byte lane of the data memory: synchronous write-first RAM.
module dmem_lane_ram #(
   parameter int DEPTH = 4096,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [IDX_W-1:0] addr_i,
   input  logic [7:0]       wdata_i,
   output logic [7:0]       rdata_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
         rdata_o       <= wdata_i;
      end else begin
         rdata_o <= mem_q[addr_i];
      end
   end

endmodule

// File: rtl/data_mem_bytelane.sv
// Byte/half/word data memory with alignment checks, load extension and a post-reset clear sweep.
// Optional DMEM_MMIO_EN maps the 0xF top-nibble region onto four 32-bit registers.
module data_mem_bytelane
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4096,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   localparam int IDX_W = $clog2(DEPTH);

   if (DATA_W != 32) begin : g_bad_width
      $error("data_mem_bytelane supports only DATA_W == 32");
   end

   dmem_state_e      state_q, state_d;
   logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

   logic             accept, req_err, wr_ok, is_mmio, clearing;
   logic [3:0]       mask;
   logic [31:0]      wdata_rep;
   logic [IDX_W-1:0] word_idx, ram_addr;
   logic [3:0]       ram_we;
   logic [31:0]      ram_wdata, ram_rdata, load_word;

   logic             resp_valid_q, resp_load_q, resp_err_q, resp_uns_q;
   logic [1:0]       resp_size_q, resp_lo_q;

   logic             unused_addr;
   assign unused_addr = ^req_addr;

   function automatic logic [31:0] replicate(input logic [31:0] wd, input logic [1:0] size);
      logic [31:0] r;
      case (size)
         SZ_BYTE: r = {4{wd[7:0]}};
         SZ_HALF: r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [1:0] lo);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {lo, 3'b000};
      case (size)
         SZ_BYTE: r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         SZ_HALF: r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         SZ_WORD: r = word;
         default: r = '0;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         ST_CLEAR: begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
         end
         ST_IDLE: ;
         default: state_d = ST_CLEAR;
      endcase
   end

   assign req_ready = (state_q == ST_IDLE);
   assign accept    = req_valid && req_ready && !rst;
   assign clearing  = (state_q == ST_CLEAR) && !rst;

   assign req_err   = (req_size == 2'b11)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
   assign wr_ok     = accept && req_we && !req_err;
   assign mask      = lane_mask(req_size, req_addr[1:0]);
   assign wdata_rep = replicate(req_wdata, req_size);
   assign word_idx  = req_addr[2 +: IDX_W];

   // The clear sweep owns the RAM port until the FSM reaches IDLE.
   assign ram_addr  = (state_q == ST_CLEAR) ? clr_idx_q : word_idx;
   assign ram_wdata = (state_q == ST_CLEAR) ? 32'h0 : wdata_rep;
   assign ram_we    = clearing              ? 4'hF
                    : (wr_ok && !is_mmio)  ? mask
                    :                        4'h0;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      dmem_lane_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
         .clk     (clk),
         .we_i    (ram_we[g]),
         .addr_i  (ram_addr),
         .wdata_i (ram_wdata[8*g +: 8]),
         .rdata_o (ram_rdata[8*g +: 8])
      );
   end

`ifdef DMEM_MMIO_EN
   logic [31:0] mmio_q [4];
   logic [31:0] mmio_rd_q;
   logic        resp_mmio_q;

   assign is_mmio = (req_addr[ADDR_W-1 -: 4] == MMIO_TAG);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) mmio_q[i] <= '0;
         resp_mmio_q <= 1'b0;
      end else begin
         if (wr_ok && is_mmio) begin
            for (int b = 0; b < 4; b++)
               if (mask[b]) mmio_q[req_addr[3:2]][8*b +: 8] <= wdata_rep[8*b +: 8];
         end
         if (accept) begin
            resp_mmio_q <= is_mmio;
            mmio_rd_q   <= mmio_q[req_addr[3:2]];
         end
      end
   end

   assign load_word = resp_mmio_q ? mmio_rd_q : ram_rdata;
`else
   assign is_mmio   = 1'b0;
   assign load_word = ram_rdata;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_CLEAR;
         clr_idx_q    <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_idx_q    <= clr_idx_d;
         resp_valid_q <= accept;
      end
   end

   // Response stage: remember how to shape the word the RAM returns next cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         resp_load_q <= !req_we;
         resp_err_q  <= req_err;
         resp_uns_q  <= req_unsigned;
         resp_size_q <= req_size;
         resp_lo_q   <= req_addr[1:0];
      end
   end

   assign resp_valid = resp_valid_q && !rst;
   assign resp_err   = resp_valid && resp_err_q;
   assign resp_rdata = (resp_valid && resp_load_q && !resp_err_q)
                     ? extend_load(load_word, resp_size_q, resp_uns_q, resp_lo_q)
                     : 32'h0;

endmodule
